// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM decoder: synchronizes the input and measures high time and period.
// A timeout reports a stuck-high or stuck-low input.
module pwm_capture #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_vld,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic [CNT_W-1:0] pcnt_inc, hcnt_inc;
  logic             rise, fall, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= PWM_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  assign pcnt_inc = (pcnt >= TMO) ? TMO : pcnt + ONE;
  assign hcnt_inc = (hcnt >= TMO) ? TMO : hcnt + ONE;

  // Once stuck, pcnt sits at TMO; gating on stuck keeps the strobe to a single pulse.
  assign timeout = (pcnt == TMO) && !rise && !stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      high_time <= '0;
      period    <= '0;
      meas_vld  <= 1'b0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
    end else begin
      meas_vld <= 1'b0;
      if (timeout) begin
        stuck     <= 1'b1;
        stuck_lvl <= s2;
        state     <= IDLE;
        high_time <= s2 ? '1 : '0;
        period    <= '0;
        meas_vld  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= HIGH;
              pcnt  <= ONE;
              hcnt  <= ONE;
              stuck <= 1'b0;
            end else begin
              pcnt <= pcnt_inc;
            end
          end
          HIGH: begin
            pcnt <= pcnt_inc;
            if (fall) begin
              state <= LOW;
            end else if (s2) begin
              hcnt <= hcnt_inc;
            end
          end
          LOW: begin
            // The rise cycle opens the next period, so the new counts start at 1.
            if (rise) begin
              period    <= pcnt;
              high_time <= hcnt;
              meas_vld  <= 1'b1;
              pcnt      <= ONE;
              hcnt      <= ONE;
              state     <= HIGH;
            end else begin
              pcnt <= pcnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [11:0] high_time, period;
  logic        meas_vld, stuck, stuck_lvl;

  pwm_capture #(.CNT_W(12), .TIMEOUT(4000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PWM_in    (pwm_in),
    .high_time (high_time),
    .period    (period),
    .meas_vld  (meas_vld),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] p;
    logic        s;
    logic        l;
  } exp_t;

  exp_t q[$];
  exp_t got, want;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   first_vld = -1;
  int   strobes = 0;
  int   release_cyc = 0;
  bit   have_prev = 0;
  int   prev_h = 0, prev_p = 0;
  logic exp_lvl = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && meas_vld) begin
      got.h = high_time;
      got.p = period;
      got.s = stuck;
      got.l = stuck_lvl;
      strobes++;
      if (first_vld < 0) first_vld = cyc;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe got h=%0d p=%0d stuck=%0b lvl=%0b expected no strobe",
                 got.h, got.p, got.s, got.l);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL meas got h=%0d p=%0d stuck=%0b lvl=%0b expected h=%0d p=%0d stuck=%0b lvl=%0b",
                   got.h, got.p, got.s, got.l, want.h, want.p, want.s, want.l);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, g, e);
    end
  endtask

  task automatic push_exp(input int h, input int p, input logic s);
    exp_t e;
    e.h = 12'(h);
    e.p = 12'(p);
    e.s = s;
    e.l = exp_lvl;
    q.push_back(e);
  endtask

  // Called at posedge+3; each level is sampled on n clock edges.
  task automatic hold(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic run_period(input int h, input int l);
    if (have_prev) push_exp(prev_h, prev_p, 1'b0);
    hold(1'b1, h);
    hold(1'b0, l);
    have_prev = 1;
    prev_h = h;
    prev_p = h + l;
  endtask

  initial begin
    @(posedge clk);
    #3;
    check("reset_high_time", high_time, 0);
    check("reset_period", period, 0);
    check("reset_vld", meas_vld, 0);
    check("reset_stuck", {stuck, stuck_lvl}, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    release_cyc = cyc;

    // Stuck low from reset
    exp_lvl = 1'b0;
    push_exp(0, 0, 1'b1);
    hold(1'b0, 4300);
    tests++;
    if (first_vld < 0 || (first_vld - release_cyc) < 3995 || (first_vld - release_cyc) > 4005) begin
      fails++;
      $display("FAIL stuck_low_time got %0d expected about 4000", first_vld - release_cyc);
    end
    check("stuck_low_strobes", strobes, 1);
    check("stuck_low_flags", {stuck, stuck_lvl}, 2'b10);

    // Duty 0x200 then 0x600 on a 2048-cycle period
    repeat (4) run_period(512, 1536);
    check("duty200_stuck", stuck, 0);
    repeat (3) run_period(1536, 512);

    // Stuck high after a valid period
    push_exp(prev_h, prev_p, 1'b0);
    exp_lvl = 1'b1;
    push_exp(4095, 0, 1'b1);
    have_prev = 0;
    hold(1'b1, 5000);
    hold(1'b0, 200);
    check("stuck_high_flags", {stuck, stuck_lvl}, 2'b11);
    check("stuck_high_ht", high_time, 4095);
    run_period(100, 200);
    check("stuck_cleared", stuck, 0);
    run_period(100, 200);

    // Period of exactly TIMEOUT: rise beats timeout
    run_period(1000, 3000);
    run_period(3, 5);
    check("tmo_period_stuck", stuck, 0);
    check("tmo_period_value", period, 4000);

    // Reset inside a HIGH phase
    run_period(3, 5);
    run_period(3, 5);
    pwm_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #3;
    check("midreset_high_time", high_time, 0);
    check("midreset_period", period, 0);
    check("midreset_flags", {meas_vld, stuck, stuck_lvl}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    pwm_in = 1'b0;
    have_prev = 0;
    exp_lvl = 1'b0;
    hold(1'b0, 4);
    repeat (3) run_period(3, 5);
    push_exp(prev_h, prev_p, 1'b0);
    hold(1'b1, 10);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    check("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
